uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Memory-mapped transmit controller for the core's UART transmitter.
- Accepts bytes from the CPU load/store bus into a small FIFO and sequences them one frame at a time onto the transmitter's `write`/`write_data` inputs.
- The transmitter has no busy output, so this block times each frame itself and holds `write_data` stable for the whole frame.
- Exposes status, control and an empty interrupt to software.

Parameters:
- ClockFreqHz, 10000000, system clock frequency.
- BaudRate, 9600, line rate; must match the transmitter instance.
- DataBitsSizeInt, 8, data bits per frame.
- FifoDepth, 8, TX FIFO entries; power of two, minimum 2.
- GuardCycles, 2, idle cycles added after each frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- bus_addr  in  4  byte address: 0x0 DATA, 0x4 STATUS, 0x8 CTRL
- bus_wr  in  1  write strobe, single cycle
- bus_rd  in  1  read strobe, single cycle
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, valid the cycle after bus_rd
- tx_write  out  1  one-cycle start pulse to the transmitter
- tx_data  out  DataBitsSizeInt  byte to the transmitter, held for the whole frame
- irq_empty  out  1  level: FIFO empty AND not busy AND CTRL.irq_en

Interface (already decided): single clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Derived constants:
  - SClkPeriod = ClockFreqHz/BaudRate (integer divide).
  - BitCycles = SClkPeriod+1.
  - FrameCycles = (DataBitsSizeInt+2)*BitCycles + GuardCycles.
  - Frame counter width = $clog2(FrameCycles)+1.
- Reset values:
  - Outputs: tx_write=0, tx_data=0, bus_rdata=0, irq_empty=0.
  - Internal: FIFO empty, overflow=0, CTRL.tx_en=1, CTRL.irq_en=0, state IDLE.
- DATA write: pushes bus_wdata[DataBitsSizeInt-1:0].
  - If FIFO is full at the start of the cycle, the byte is dropped and sticky overflow is set, even if a pop occurs in the same cycle.
- DATA read returns 0.
- STATUS read fields:
  - bit0 full, bit1 empty, bit2 busy, bit3 overflow.
  - bits[15:8] FIFO count, zero-extended.
  - All other bits 0.
- STATUS write: writing 1 to bit3 clears overflow (W1C). If a W1C and a new overflow occur in the same cycle, overflow stays set.
- CTRL read/write:
  - bit0 tx_en, bit1 irq_en.
  - bit2 flush: write-only, reads 0. It empties the FIFO the same cycle and does not abort a frame in progress.
- Unmapped addresses: writes are ignored, reads return 0.
- State machine:
  - IDLE: if tx_en and FIFO not empty, pop head into tx_data and go to START.
  - START: assert tx_write for exactly one cycle, load frame counter with FrameCycles-1, go to SEND.
  - SEND: decrement every cycle; at 0 go to IDLE. tx_data is unchanged throughout.
- busy = state != IDLE.
- Back-to-back bytes: the next tx_write pulse occurs exactly FrameCycles+2 cycles after the previous one (1 IDLE + 1 START + FrameCycles).
- Clearing tx_en mid-frame finishes the current frame, then the block holds in IDLE with the FIFO retained.
- Simultaneous push and pop (not full): both take effect; count is unchanged.
- FIFO pointers use $clog2(FifoDepth)+1 bits, with full/empty decided by the MSB compare; wrap-around is natural.
- bus_wr and bus_rd asserted in the same cycle: both are serviced; the read returns pre-write state.
- Reset asserted mid-frame: immediate return to reset values; tx_write is never left high.

Decomposition:
- Package `uart_pkg`:
  - tx_ctrl_state_e enum {IDLE, START, SEND}.
  - Register offset localparams (ADDR_DATA, ADDR_STATUS, ADDR_CTRL).
  - STATUS/CTRL bit-index localparams.
- One sub-module, `sync_fifo` (parameters Width, Depth):
  - Ports: push, pop, wdata, rdata (show-ahead), full, empty, count, flush.
- The transmitter itself is instantiated by the parent, not inside this block.

Test Plan (ClockFreqHz=1000000, BaudRate=100000, FifoDepth=4 → SClkPeriod=10, FrameCycles=112):
- Reset, then read STATUS → 0x00000002 (empty); irq_empty=0; tx_write never pulses.
- Write DATA=0x41 at cycle T → tx_write pulses at T+2, tx_data=0x41 stable for 113 cycles; STATUS.busy=1 then 0; irq_empty=1 with irq_en=1.
- Write 0x10, 0x20, 0x30 back-to-back → three tx_write pulses spaced exactly 114 cycles apart, tx_data 0x10, 0x20, 0x30 in order.
- With tx_en=0, write 6 bytes → STATUS count=4, full=1, overflow=1; W1C bit3 → overflow=0; set tx_en=1 → exactly 4 frames sent.
- Write 3 bytes, then CTRL flush during the first frame → first frame completes, no further tx_write, STATUS empty=1.
- Assert rst_n=0 mid-SEND → tx_write=0 and tx_data=0 immediately; after release, STATUS=0x00000002.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the UART transmit controller.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND
  } tx_ctrl_state_e;

  // Register byte offsets on the load/store bus
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;
  localparam int unsigned STAT_CNT_MSB = 15;

  // CTRL bit positions
  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_FLUSH  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with flush; extra pointer MSB separates full from empty.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: FIFO-buffered bytes, self-timed frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreqHz     = 10000000,
  parameter int unsigned BaudRate        = 9600,
  parameter int unsigned DataBitsSizeInt = 8,
  parameter int unsigned FifoDepth       = 8,
  parameter int unsigned GuardCycles     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 bus_addr,
  input  logic                       bus_wr,
  input  logic                       bus_rd,
  input  logic [31:0]                bus_wdata,
  output logic [31:0]                bus_rdata,
  output logic                       tx_write,
  output logic [DataBitsSizeInt-1:0] tx_data,
  output logic                       irq_empty
);

  localparam int unsigned SClkPeriod  = ClockFreqHz / BaudRate;
  localparam int unsigned BitCycles   = SClkPeriod + 1;
  localparam int unsigned FrameCycles = (DataBitsSizeInt + 2) * BitCycles + GuardCycles;
  localparam int unsigned CntW        = $clog2(FrameCycles) + 1;
  localparam int unsigned FifoCntW    = $clog2(FifoDepth) + 1;

  tx_ctrl_state_e             state;
  logic [CntW-1:0]            frame_cnt;
  logic                       tx_en;
  logic                       irq_en;
  logic                       overflow;

  logic                       wr_data, wr_status, wr_ctrl;
  logic                       fifo_push, fifo_pop, fifo_flush;
  logic                       fifo_full, fifo_empty;
  logic [DataBitsSizeInt-1:0] fifo_rdata;
  logic [FifoCntW-1:0]        fifo_count;
  logic                       busy;
  logic [31:0]                status_word;
  logic [31:0]                rd_mux;
  logic                       unused_wdata;

  assign unused_wdata = ^bus_wdata;

  assign wr_data   = bus_wr && (bus_addr == ADDR_DATA);
  assign wr_status = bus_wr && (bus_addr == ADDR_STATUS);
  assign wr_ctrl   = bus_wr && (bus_addr == ADDR_CTRL);

  // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped
  assign fifo_push  = wr_data && !fifo_full;
  assign fifo_flush = wr_ctrl && bus_wdata[CTRL_FLUSH];
  assign fifo_pop   = (state == IDLE) && tx_en && !fifo_empty;

  assign busy      = (state != IDLE);
  assign irq_empty = fifo_empty && !busy && irq_en;

  sync_fifo #(
    .Width (DataBitsSizeInt),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (bus_wdata[DataBitsSizeInt-1:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control bits and sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tx_en  <= bus_wdata[CTRL_TX_EN];
        irq_en <= bus_wdata[CTRL_IRQ_EN];
      end
      if (wr_data && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_status && bus_wdata[STAT_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Read mux built from current register state, so a same-cycle write is not yet visible
  always_comb begin
    status_word                           = '0;
    status_word[STAT_FULL]                = fifo_full;
    status_word[STAT_EMPTY]               = fifo_empty;
    status_word[STAT_BUSY]                = busy;
    status_word[STAT_OVF]                 = overflow;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(fifo_count);
    rd_mux                                = '0;
    case (bus_addr)
      ADDR_STATUS: rd_mux = status_word;
      ADDR_CTRL: begin
        rd_mux[CTRL_TX_EN]  = tx_en;
        rd_mux[CTRL_IRQ_EN] = irq_en;
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= '0;
    end else begin
      bus_rdata <= bus_rd ? rd_mux : '0;
    end
  end

  // Frame sequencer: pop into tx_data, one-cycle start pulse, then count out the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_write  <= 1'b0;
      tx_data   <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_write <= 1'b0;
          if (fifo_pop) begin
            tx_data  <= fifo_rdata;
            tx_write <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_write  <= 1'b0;
          frame_cnt <= CntW'(FrameCycles - 1);
          state     <= SEND;
        end
        SEND: begin
          tx_write <= 1'b0;
          if (frame_cnt == '0) begin
            state <= IDLE;
          end else begin
            frame_cnt <= frame_cnt - 1'b1;
          end
        end
        default: begin
          tx_write <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (1 MHz clock, 100 kbaud, 4-entry FIFO).
module tb_uart_tx_ctrl;

  localparam int unsigned FRAME = 112;
  localparam int unsigned SPACE = FRAME + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        irq_empty;

  int errors = 0;
  int checks = 0;

  int       cyc = 0;
  int       last_wr_cyc = 0;
  int       pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  logic [7:0] frame_data = '0;
  int       frame_left = 0;
  int       stab_err = 0;
  int       double_pulse = 0;
  logic     prev_tx_write = 1'b0;

  uart_tx_ctrl #(
    .ClockFreqHz     (1000000),
    .BaudRate        (100000),
    .DataBitsSizeInt (8),
    .FifoDepth       (4),
    .GuardCycles     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_write  (tx_write),
    .tx_data   (tx_data),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  // Cycle log of DATA writes and start pulses; tx_data must hold for 113 cycles per frame
  always @(posedge clk) begin
    if (bus_wr && bus_addr == 4'h0) last_wr_cyc = cyc;
    if (!rst_n) begin
      frame_left = 0;
    end else if (tx_write) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(tx_data);
      frame_data = tx_data;
      frame_left = FRAME;
      if (prev_tx_write) double_pulse++;
    end else if (frame_left > 0) begin
      if (tx_data !== frame_data) stab_err++;
      frame_left--;
    end
    prev_tx_write = tx_write;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pulse_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pulse_count", 32'(pulse_cyc.size()), 32'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int          t0;

    rst_n     = 1'b0;
    bus_addr  = '0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = '0;
    idle(3);
    check("rst_tx_write", 32'(tx_write), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", 32'(irq_empty), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Reset state visible through registers
    bus_read(4'h4, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    bus_read(4'h8, rd);
    check("ctrl_after_reset", rd, 32'h0000_0001);
    check("irq_irq_en_off", 32'(irq_empty), 32'h0);
    bus_read(4'h0, rd);
    check("data_reads_zero", rd, 32'h0);
    bus_read(4'hC, rd);
    check("unmapped_reads_zero", rd, 32'h0);
    idle(5);
    check("no_pulse_after_reset", 32'(pulse_cyc.size()), 32'h0);

    // Single byte
    bus_write(4'h8, 32'h3);
    check("irq_empty_set", 32'(irq_empty), 32'h1);
    bus_write(4'h0, 32'h41);
    t0 = last_wr_cyc;
    wait_pulses(1, 20);
    check("single_latency", 32'(pulse_cyc[0] - t0), 32'd2);
    check("single_data", 32'(pulse_dat[0]), 32'h41);
    bus_read(4'h4, rd);
    check("status_busy", rd, 32'h0000_0006);
    check("irq_while_busy", 32'(irq_empty), 32'h0);
    idle(FRAME + 5);
    bus_read(4'h4, rd);
    check("status_done", rd, 32'h0000_0002);
    check("irq_after_frame", 32'(irq_empty), 32'h1);

    // Three bytes back-to-back
    bus_write(4'h0, 32'h10);
    t0 = last_wr_cyc;
    bus_write(4'h0, 32'h20);
    bus_write(4'h0, 32'h30);
    wait_pulses(4, 3 * SPACE + 20);
    check("b2b_latency", 32'(pulse_cyc[1] - t0), 32'd2);
    check("b2b_space1", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(SPACE));
    check("b2b_space2", 32'(pulse_cyc[3] - pulse_cyc[2]), 32'(SPACE));
    check("b2b_data0", 32'(pulse_dat[1]), 32'h10);
    check("b2b_data1", 32'(pulse_dat[2]), 32'h20);
    check("b2b_data2", 32'(pulse_dat[3]), 32'h30);
    idle(FRAME + 5);

    // Overflow with transmitter disabled
    bus_write(4'h8, 32'h2);
    for (int i = 0; i < 6; i++) bus_write(4'h0, 32'(8'hA0 + i));
    bus_read(4'h4, rd);
    check("status_full_ovf", rd, 32'h0000_0409);
    check("irq_when_full", 32'(irq_empty), 32'h0);
    idle(20);
    check("hold_when_disabled", 32'(pulse_cyc.size()), 32'd4);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd);
    check("status_ovf_cleared", rd, 32'h0000_0401);
    bus_write(4'h8, 32'h3);
    wait_pulses(8, 4 * SPACE + 20);
    for (int i = 0; i < 4; i++) check("drain_data", 32'(pulse_dat[4 + i]), 32'(8'hA0 + i));
    idle(SPACE + 20);
    check("drain_no_extra", 32'(pulse_cyc.size()), 32'd8);
    bus_read(4'h4, rd);
    check("status_drained", rd, 32'h0000_0002);

    // Flush during a frame
    bus_write(4'h0, 32'h51);
    bus_write(4'h0, 32'h52);
    bus_write(4'h0, 32'h53);
    wait_pulses(9, 20);
    idle(5);
    bus_write(4'h8, 32'h7);
    bus_read(4'h4, rd);
    check("status_flushed_busy", rd, 32'h0000_0006);
    bus_read(4'h8, rd);
    check("ctrl_flush_reads0", rd, 32'h0000_0003);
    idle(2 * SPACE + 20);
    check("flush_no_more", 32'(pulse_cyc.size()), 32'd9);
    check("flush_frame_data", 32'(pulse_dat[8]), 32'h51);
    bus_read(4'h4, rd);
    check("status_after_flush", rd, 32'h0000_0002);
    check("tx_data_stable", 32'(stab_err), 32'h0);
    check("single_cycle_pulse", 32'(double_pulse), 32'h0);

    // Reset in the middle of a frame
    bus_write(4'h0, 32'h77);
    bus_write(4'h0, 32'h78);
    wait_pulses(10, 20);
    idle(20);
    rst_n = 1'b0;
    #1;
    check("midreset_tx_write", 32'(tx_write), 32'h0);
    check("midreset_tx_data", 32'(tx_data), 32'h0);
    check("midreset_irq", 32'(irq_empty), 32'h0);
    idle(3);
    rst_n = 1'b1;
    bus_read(4'h4, rd);
    check("status_after_midreset", rd, 32'h0000_0002);
    bus_read(4'h8, rd);
    check("ctrl_after_midreset", rd, 32'h0000_0001);
    idle(SPACE + 20);
    check("no_pulse_after_midreset", 32'(pulse_cyc.size()), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
